// File: rtl/sound_ram_arbiter_if.sv
// Sound RAM arbiter bus: DOC fetch port, GLU host port and syncram port.
// slave = arbiter side, master = surrounding DOC/GLU/RAM side.
interface sound_ram_arbiter_if #(
    parameter int ADDR_W = 16
);
    logic              doc_req;
    logic [ADDR_W-1:0] doc_addr;
    logic              doc_ack;
    logic [7:0]        doc_rdata;

    logic              host_req;
    logic              host_wr;
    logic [ADDR_W-1:0] host_addr;
    logic [7:0]        host_wdata;
    logic              host_busy;
    logic              host_ack;
    logic [7:0]        host_rdata;
    logic              host_ovf;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;

    modport slave (
        input  doc_req,
        input  doc_addr,
        output doc_ack,
        output doc_rdata,
        input  host_req,
        input  host_wr,
        input  host_addr,
        input  host_wdata,
        output host_busy,
        output host_ack,
        output host_rdata,
        output host_ovf,
        output ram_addr,
        output ram_we,
        output ram_wdata,
        input  ram_rdata
    );

    modport master (
        output doc_req,
        output doc_addr,
        input  doc_ack,
        input  doc_rdata,
        output host_req,
        output host_wr,
        output host_addr,
        output host_wdata,
        input  host_busy,
        input  host_ack,
        input  host_rdata,
        input  host_ovf,
        input  ram_addr,
        input  ram_we,
        input  ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/sound_ram_arbiter.sv
// Sound RAM arbiter: sequences DOC sample fetches and GLU host accesses
// onto the single-port syncram, with a wait counter bounding host latency.
module sound_ram_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int MAX_WAIT = 8
) (
    input logic                CLK_14M,
    input logic                reset_n,
    sound_ram_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DOC_ADR,
        S_DOC_DAT,
        S_HOST_ADR,
        S_HOST_DAT,
        S_HOST_WR
    } state_e;

    localparam logic [7:0] WaitMax = 8'(MAX_WAIT);

    // Reset asserts asynchronously, releases on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_n_int;

    always_ff @(posedge CLK_14M or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_q[1];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] doc_addr_q, doc_addr_d;
    logic [7:0]        doc_rdata_q, doc_rdata_d;
    logic [7:0]        host_rdata_q, host_rdata_d;
    logic              pend_q, pend_d;
    logic              pend_wr_q, pend_wr_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [7:0]        pend_wdata_q, pend_wdata_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        wait_q, wait_d;

    logic              doc_ack;
    logic              host_ack;
    logic              host_state;
    logic              host_grant;
    logic              accept;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_wdata;

    always_comb begin
        doc_ack    = 1'b0;
        host_ack   = 1'b0;
        host_state = 1'b0;
        ram_addr   = '0;
        ram_we     = 1'b0;
        ram_wdata  = '0;
        unique case (state_q)
            S_DOC_ADR: begin
                ram_addr = doc_addr_q;
            end
            S_DOC_DAT: begin
                ram_addr = doc_addr_q;
                doc_ack  = 1'b1;
            end
            S_HOST_ADR: begin
                ram_addr   = pend_addr_q;
                host_state = 1'b1;
            end
            S_HOST_DAT: begin
                ram_addr   = pend_addr_q;
                host_ack   = 1'b1;
                host_state = 1'b1;
            end
            S_HOST_WR: begin
                ram_addr   = pend_addr_q;
                ram_wdata  = pend_wdata_q;
                ram_we     = 1'b1;
                host_ack   = 1'b1;
                host_state = 1'b1;
            end
            default: begin
                ram_addr = '0;
            end
        endcase
    end

    // Starved host wins first, then DOC, then an ordinary host grant.
    always_comb begin
        state_d    = state_q;
        doc_addr_d = doc_addr_q;
        host_grant = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pend_q && (wait_q == WaitMax)) begin
                    host_grant = 1'b1;
                    state_d    = pend_wr_q ? S_HOST_WR : S_HOST_ADR;
                end else if (bus.doc_req) begin
                    state_d    = S_DOC_ADR;
                    doc_addr_d = bus.doc_addr;
                end else if (pend_q) begin
                    host_grant = 1'b1;
                    state_d    = pend_wr_q ? S_HOST_WR : S_HOST_ADR;
                end
            end
            S_DOC_ADR:  state_d = S_DOC_DAT;
            S_DOC_DAT:  state_d = S_IDLE;
            S_HOST_ADR: state_d = S_HOST_DAT;
            S_HOST_DAT: state_d = S_IDLE;
            S_HOST_WR:  state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    assign accept = bus.host_req && (!pend_q || host_ack);

    always_comb begin
        pend_d       = pend_q;
        pend_wr_d    = pend_wr_q;
        pend_addr_d  = pend_addr_q;
        pend_wdata_d = pend_wdata_q;
        ovf_d        = ovf_q;
        if (accept) begin
            pend_d       = 1'b1;
            pend_wr_d    = bus.host_wr;
            pend_addr_d  = bus.host_addr;
            pend_wdata_d = bus.host_wdata;
        end else if (host_ack) begin
            pend_d = 1'b0;
        end
        if (bus.host_req && pend_q && !host_ack) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        wait_d = wait_q;
        if (host_grant || !pend_q) begin
            wait_d = '0;
        end else if (!host_state && (wait_q != WaitMax)) begin
            wait_d = wait_q + 8'd1;
        end
    end

    always_comb begin
        doc_rdata_d  = doc_rdata_q;
        host_rdata_d = host_rdata_q;
        if (doc_ack) begin
            doc_rdata_d = bus.ram_rdata;
        end
        if (state_q == S_HOST_DAT) begin
            host_rdata_d = bus.ram_rdata;
        end
    end

    always_ff @(posedge CLK_14M or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q      <= S_IDLE;
            doc_addr_q   <= '0;
            doc_rdata_q  <= '0;
            host_rdata_q <= '0;
            pend_q       <= 1'b0;
            pend_wr_q    <= 1'b0;
            pend_addr_q  <= '0;
            pend_wdata_q <= '0;
            ovf_q        <= 1'b0;
            wait_q       <= '0;
        end else begin
            state_q      <= state_d;
            doc_addr_q   <= doc_addr_d;
            doc_rdata_q  <= doc_rdata_d;
            host_rdata_q <= host_rdata_d;
            pend_q       <= pend_d;
            pend_wr_q    <= pend_wr_d;
            pend_addr_q  <= pend_addr_d;
            pend_wdata_q <= pend_wdata_d;
            ovf_q        <= ovf_d;
            wait_q       <= wait_d;
        end
    end

    assign bus.doc_ack    = doc_ack;
    assign bus.doc_rdata  = doc_rdata_q;
    assign bus.host_busy  = pend_q;
    assign bus.host_ack   = host_ack;
    assign bus.host_rdata = host_rdata_q;
    assign bus.host_ovf   = ovf_q;
    assign bus.ram_addr   = ram_addr;
    assign bus.ram_we     = ram_we;
    assign bus.ram_wdata  = ram_wdata;

endmodule

// File: tb/tb_sound_ram_arbiter.sv
// Directed vector bench for sound_ram_arbiter with a behavioural syncram.
// Per-cycle table for the basic flows, hand sequences for starvation/reset.
module tb_sound_ram_arbiter;

    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    sound_ram_arbiter_if #(.ADDR_W(16)) bus ();

    sound_ram_arbiter #(
        .ADDR_W  (16),
        .MAX_WAIT(8)
    ) dut (
        .CLK_14M(clk),
        .reset_n(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:65535];
    logic        pl_we   = 1'b0;
    logic [15:0] pl_addr = 16'h0;
    logic [7:0]  pl_data = 8'h0;

    always @(posedge clk) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    typedef struct {
        logic        dreq;
        logic [15:0] daddr;
        logic        hreq;
        logic        hwr;
        logic [15:0] haddr;
        logic [7:0]  hwd;
        logic        dack;
        logic [7:0]  drd;
        logic        busy;
        logic        hack;
        logic [7:0]  hrd;
        logic        ovf;
        logic [15:0] raddr;
        logic        we;
        logic [7:0]  rwd;
    } vec_t;

    vec_t tv [28];
    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic dr, input logic [15:0] da,
                         input logic hr, input logic hw,
                         input logic [15:0] ha, input logic [7:0] hd);
        bus.doc_req    = dr;
        bus.doc_addr   = da;
        bus.host_req   = hr;
        bus.host_wr    = hw;
        bus.host_addr  = ha;
        bus.host_wdata = hd;
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_we   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " doc_ack"},    bus.doc_ack,    16'h0);
        chk({tag, " doc_rdata"},  bus.doc_rdata,  16'h0);
        chk({tag, " host_busy"},  bus.host_busy,  16'h0);
        chk({tag, " host_ack"},   bus.host_ack,   16'h0);
        chk({tag, " host_rdata"}, bus.host_rdata, 16'h0);
        chk({tag, " host_ovf"},   bus.host_ovf,   16'h0);
        chk({tag, " ram_addr"},   bus.ram_addr,   16'h0);
        chk({tag, " ram_we"},     bus.ram_we,     16'h0);
        chk({tag, " ram_wdata"},  bus.ram_wdata,  16'h0);
    endtask

    initial begin
        //         dreq daddr    hreq hwr haddr     hwd
        //         dack drd    busy hack hrd    ovf raddr    we rwd
        tv[0]  = '{N, 16'h0000, N, N, 16'h0000, 8'h00,
                   N, 8'h00, N, N, 8'h00, N, 16'h0000, N, 8'h00};
        tv[1]  = '{N, 16'h0000, Y, Y, 16'h1234, 8'h5A,
                   N, 8'h00, N, N, 8'h00, N, 16'h0000, N, 8'h00};
        tv[2]  = '{N, 16'h0000, N, N, 16'h0000, 8'h00,
                   N, 8'h00, Y, N, 8'h00, N, 16'h0000, N, 8'h00};
        tv[3]  = '{N, 16'h0000, N, N, 16'h0000, 8'h00,
                   N, 8'h00, Y, Y, 8'h00, N, 16'h1234, Y, 8'h5A};
        tv[4]  = '{N, 16'h0000, Y, N, 16'h1234, 8'h00,
                   N, 8'h00, N, N, 8'h00, N, 16'h0000, N, 8'h00};
        tv[5]  = '{N, 16'h0000, N, N, 16'h0000, 8'h00,
                   N, 8'h00, Y, N, 8'h00, N, 16'h0000, N, 8'h00};
        tv[6]  = '{N, 16'h0000, N, N, 16'h0000, 8'h00,
                   N, 8'h00, Y, N, 8'h00, N, 16'h1234, N, 8'h00};
        tv[7]  = '{N, 16'h0000, N, N, 16'h0000, 8'h00,
                   N, 8'h00, Y, Y, 8'h00, N, 16'h1234, N, 8'h00};
        tv[8]  = '{N, 16'h0000, N, N, 16'h0000, 8'h00,
                   N, 8'h00, N, N, 8'h5A, N, 16'h0000, N, 8'h00};
        tv[9]  = '{Y, 16'h0100, N, N, 16'h0000, 8'h00,
                   N, 8'h00, N, N, 8'h5A, N, 16'h0000, N, 8'h00};
        tv[10] = '{Y, 16'h0100, N, N, 16'h0000, 8'h00,
                   N, 8'h00, N, N, 8'h5A, N, 16'h0100, N, 8'h00};
        tv[11] = '{Y, 16'h0100, N, N, 16'h0000, 8'h00,
                   Y, 8'h00, N, N, 8'h5A, N, 16'h0100, N, 8'h00};
        tv[12] = '{N, 16'h0000, N, N, 16'h0000, 8'h00,
                   N, 8'hC3, N, N, 8'h5A, N, 16'h0000, N, 8'h00};
        tv[13] = '{N, 16'h0000, N, N, 16'h0000, 8'h00,
                   N, 8'hC3, N, N, 8'h5A, N, 16'h0000, N, 8'h00};
        tv[14] = '{Y, 16'h0001, Y, N, 16'h0002, 8'h00,
                   N, 8'hC3, N, N, 8'h5A, N, 16'h0000, N, 8'h00};
        tv[15] = '{Y, 16'h0001, N, N, 16'h0000, 8'h00,
                   N, 8'hC3, Y, N, 8'h5A, N, 16'h0001, N, 8'h00};
        tv[16] = '{Y, 16'h0001, N, N, 16'h0000, 8'h00,
                   Y, 8'hC3, Y, N, 8'h5A, N, 16'h0001, N, 8'h00};
        tv[17] = '{N, 16'h0000, N, N, 16'h0000, 8'h00,
                   N, 8'h11, Y, N, 8'h5A, N, 16'h0000, N, 8'h00};
        tv[18] = '{N, 16'h0000, N, N, 16'h0000, 8'h00,
                   N, 8'h11, Y, N, 8'h5A, N, 16'h0002, N, 8'h00};
        tv[19] = '{N, 16'h0000, N, N, 16'h0000, 8'h00,
                   N, 8'h11, Y, Y, 8'h5A, N, 16'h0002, N, 8'h00};
        tv[20] = '{N, 16'h0000, N, N, 16'h0000, 8'h00,
                   N, 8'h11, N, N, 8'h22, N, 16'h0000, N, 8'h00};
        tv[21] = '{N, 16'h0000, Y, N, 16'h0100, 8'h00,
                   N, 8'h11, N, N, 8'h22, N, 16'h0000, N, 8'h00};
        tv[22] = '{N, 16'h0000, Y, Y, 16'h0003, 8'h77,
                   N, 8'h11, Y, N, 8'h22, N, 16'h0000, N, 8'h00};
        tv[23] = '{N, 16'h0000, N, N, 16'h0000, 8'h00,
                   N, 8'h11, Y, N, 8'h22, Y, 16'h0100, N, 8'h00};
        tv[24] = '{N, 16'h0000, Y, Y, 16'h0004, 8'h99,
                   N, 8'h11, Y, Y, 8'h22, Y, 16'h0100, N, 8'h00};
        tv[25] = '{N, 16'h0000, N, N, 16'h0000, 8'h00,
                   N, 8'h11, Y, N, 8'hC3, Y, 16'h0000, N, 8'h00};
        tv[26] = '{N, 16'h0000, N, N, 16'h0000, 8'h00,
                   N, 8'h11, Y, Y, 8'hC3, Y, 16'h0004, Y, 8'h99};
        tv[27] = '{N, 16'h0000, N, N, 16'h0000, 8'h00,
                   N, 8'h11, N, N, 8'hC3, Y, 16'h0000, N, 8'h00};

        drive(N, 16'h0, N, N, 16'h0, 8'h00);
        preload(16'h0100, 8'hC3);
        preload(16'h0001, 8'h11);
        preload(16'h0002, 8'h22);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            drive(tv[i].dreq, tv[i].daddr, tv[i].hreq, tv[i].hwr,
                  tv[i].haddr, tv[i].hwd);
            #1;
            chk($sformatf("v%0d doc_ack", i), bus.doc_ack, tv[i].dack);
            chk($sformatf("v%0d doc_rdata", i), bus.doc_rdata, tv[i].drd);
            chk($sformatf("v%0d host_busy", i), bus.host_busy, tv[i].busy);
            chk($sformatf("v%0d host_ack", i), bus.host_ack, tv[i].hack);
            chk($sformatf("v%0d host_rdata", i), bus.host_rdata, tv[i].hrd);
            chk($sformatf("v%0d host_ovf", i), bus.host_ovf, tv[i].ovf);
            chk($sformatf("v%0d ram_addr", i), bus.ram_addr, tv[i].raddr);
            chk($sformatf("v%0d ram_we", i), bus.ram_we, tv[i].we);
            chk($sformatf("v%0d ram_wdata", i), bus.ram_wdata, tv[i].rwd);
        end

        // Starvation: DOC held high, host write granted once wait hits 8.
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (c == 0) drive(Y, 16'h0001, Y, Y, 16'h0005, 8'hAB);
            else if (c < 14) drive(Y, 16'h0001, N, N, 16'h0, 8'h00);
            else drive(N, 16'h0, N, N, 16'h0, 8'h00);
            #1;
            chk($sformatf("starve c%0d doc_ack", c), bus.doc_ack,
                {15'h0, (c == 2 || c == 5 || c == 8 || c == 13)});
            chk($sformatf("starve c%0d ram_we", c), bus.ram_we,
                {15'h0, (c == 10)});
            chk($sformatf("starve c%0d host_busy", c), bus.host_busy,
                {15'h0, (c >= 1 && c <= 10)});
            if (c == 10) begin
                chk("starve wr addr", bus.ram_addr, 16'h0005);
                chk("starve wr data", bus.ram_wdata, 16'h00AB);
            end
        end
        chk("starve mem", {8'h0, mem[16'h0005]}, 16'h00AB);

        // Reset in the middle of a DOC access with a host read queued.
        @(negedge clk);
        drive(Y, 16'h0100, Y, N, 16'h0002, 8'h00);
        @(negedge clk);
        drive(Y, 16'h0100, N, N, 16'h0, 8'h00);
        #1;
        chk("rst doc_adr addr", bus.ram_addr, 16'h0100);
        rst_n = 1'b0;
        drive(N, 16'h0, N, N, 16'h0, 8'h00);
        #1;
        chk_all_zero("midrst");
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("inrst c%0d doc_ack", c), bus.doc_ack, 16'h0);
            chk($sformatf("inrst c%0d host_ack", c), bus.host_ack, 16'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("post c%0d doc_ack", c), bus.doc_ack, 16'h0);
            chk($sformatf("post c%0d host_ack", c), bus.host_ack, 16'h0);
            chk($sformatf("post c%0d host_busy", c), bus.host_busy, 16'h0);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c < 3) drive(Y, 16'h0100, N, N, 16'h0, 8'h00);
            else drive(N, 16'h0, N, N, 16'h0, 8'h00);
            #1;
            chk($sformatf("refetch c%0d doc_ack", c), bus.doc_ack,
                {15'h0, (c == 2)});
            if (c == 1) chk("refetch addr", bus.ram_addr, 16'h0100);
            if (c >= 3) chk($sformatf("refetch c%0d rdata", c),
                            bus.doc_rdata, 16'h00C3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
